// File: rtl/countdown_sched_pkg.sv
// Shared types and defaults for the countdown scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package countdown_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default counter/delay width and requester count
    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;

    // Width of a requester index; never collapses to zero bits
    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/countdown_sched_rr_pick.sv
// Round-robin picker: first set request after index 'last', wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the winner.
module rr_pick
    import countdown_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // Scan from last+1 around the ring; the first asserted request wins,
    // so the previous owner is always considered last.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!any && req[cand]) begin
                any     = 1'b1;
                win_idx = cand;
                win     = NREQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/countdown_sched.sv
// Round-robin sharing of one external loadable down counter among NREQ requesters.
// Latency: Req seen in IDLE at t -> load at t+1, count from t+2, Done pulse at t+3+D.
// Backpressure: Req is a level; losers simply keep Req high until granted.
// Optional build macro COUNTDOWN_SCHED_ABORT_EN: owner withdrawing Req in LOAD/COUNT aborts service.
module countdown_sched
    import countdown_sched_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int NREQ = DEF_NREQ
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*n-1:0] Delay,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   Done,
    output logic              Busy,
    output logic [n-1:0]      CntR,
    output logic              CntL,
    output logic              CntE,
    input  logic [n-1:0]      CntQ
);

    localparam int IW = idx_width(NREQ);

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;

    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            withdrawn;
    logic            cnt_zero;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (Req),
        .last    (last),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

`ifdef COUNTDOWN_SCHED_ABORT_EN
    // Owner dropping its request cancels the service in progress.
    assign withdrawn = ~Req[owner];
`else
    // Withdrawal is ignored; a granted service always runs to Done.
    assign withdrawn = 1'b0;
`endif

    assign cnt_zero = (CntQ == '0);

    // Count only while nonzero, so the shared counter never wraps below 0.
    // Never overlaps CntL because CntL is only high in LOAD.
    assign CntE = (state == COUNT) && !cnt_zero;

    // Scheduler FSM with registered Grant/Done/Busy/CntR/CntL.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            last  <= IW'(NREQ - 1);
            owner <= '0;
            Grant <= '0;
            Done  <= '0;
            Busy  <= 1'b0;
            CntR  <= '0;
            CntL  <= 1'b0;
        end else begin
            Done <= '0;
            CntL <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        // Delay is sampled only here; later changes are ignored.
                        owner <= pick_idx;
                        Grant <= pick_win;
                        CntR  <= Delay[pick_idx*n +: n];
                        CntL  <= 1'b1;
                        Busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (withdrawn) begin
                        last  <= owner;
                        Grant <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (withdrawn) begin
                        last  <= owner;
                        Grant <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        // Pulse lands in the DONE cycle, aligned with Grant.
                        Done  <= Grant;
                        state <= DONE;
                    end
                end
                DONE: begin
                    last  <= owner;
                    Grant <= '0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Grant <= '0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_sched.sv
// Directed bench for countdown_sched with a behavioural external down counter.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_countdown_sched;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [NREQ-1:0]   Req   = '0;
    logic [NREQ*N-1:0] Delay = '0;
    logic [NREQ-1:0]   Grant;
    logic [NREQ-1:0]   Done;
    logic              Busy;
    logic [N-1:0]      CntR;
    logic              CntL;
    logic              CntE;
    logic [N-1:0]      CntQ  = '0;

    int n_chk  = 0;
    int n_fail = 0;

    countdown_sched #(.n(N), .NREQ(NREQ)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Req   (Req),
        .Delay (Delay),
        .Grant (Grant),
        .Done  (Done),
        .Busy  (Busy),
        .CntR  (CntR),
        .CntL  (CntL),
        .CntE  (CntE),
        .CntQ  (CntQ)
    );

    always #5 Clock = ~Clock;

    // External loadable down counter shared by all requesters
    always @(posedge Clock) begin
        if (CntL)      CntQ <= CntR;
        else if (CntE) CntQ <= CntQ - 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Counter contract holds every cycle
    always @(negedge Clock) begin
        chk("load_and_enable", {31'd0, CntL & CntE}, 32'd0);
        chk("enable_at_zero", {31'd0, CntE & (CntQ == '0)}, 32'd0);
    end

    logic seen;

    initial begin
        // ---- reset state ----
        repeat (2) tick();
        Reset = 1'b0;
        chk("rst_grant", Grant, 0);
        chk("rst_done", Done, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_cntr", CntR, 0);
        chk("rst_cntl", CntL, 0);
        chk("rst_cnte", CntE, 0);
        tick();

        // ---- single request, delay 3 ----
        Req = 4'b0001; Delay[0 +: N] = 8'd3;             // cycle t
        chk("t1_grant_t", Grant, 0);
        tick();                                           // t+1
        chk("t1_cntl", CntL, 1);
        chk("t1_cntr", CntR, 3);
        chk("t1_grant_t1", Grant, 4'b0001);
        chk("t1_busy", Busy, 1);
        tick();                                           // t+2
        chk("t1_q3", CntQ, 3);
        chk("t1_cnte", CntE, 1);
        chk("t1_cntl_off", CntL, 0);
        tick(); chk("t1_q2", CntQ, 2);
        tick(); chk("t1_q1", CntQ, 1);
        tick();                                           // t+5
        chk("t1_q0", CntQ, 0);
        chk("t1_cnte0", CntE, 0);
        chk("t1_done_early", Done, 0);
        tick();                                           // t+6
        chk("t1_done", Done, 4'b0001);
        chk("t1_grant_t6", Grant, 4'b0001);
        Req = '0;
        tick();                                           // t+7
        chk("t1_done_off", Done, 0);
        chk("t1_grant_off", Grant, 0);
        chk("t1_busy_off", Busy, 0);

        // ---- all four requesting, delays 1: rotation 0,1,2,3,0 ----
        Reset = 1'b1; tick(); Reset = 1'b0;
        Req = 4'b1111;
        for (int i = 0; i < NREQ; i++) Delay[i*N +: N] = 8'd1;
        for (int i = 0; i < 5; i++) begin
            repeat ((i == 0) ? 4 : 5) tick();
            chk($sformatf("rr_done_%0d", i), Done, 4'b0001 << (i % 4));
            chk($sformatf("rr_grant_%0d", i), Grant, 4'b0001 << (i % 4));
        end
        Req = '0;
        tick();
        chk("rr_idle", Busy, 0);

        // ---- zero delay on requester 2 ----
        Req = 4'b0100; Delay = '0;                        // cycle t
        seen = 1'b0;
        tick(); seen |= CntE;                             // t+1
        chk("z_grant", Grant, 4'b0100);
        chk("z_cntr", CntR, 0);
        tick(); seen |= CntE;                             // t+2
        chk("z_done_early", Done, 0);
        tick(); seen |= CntE;                             // t+3
        chk("z_done", Done, 4'b0100);
        chk("z_no_enable", seen, 0);
        Req = '0;
        tick();

        // ---- reset during COUNT with CntQ=5 ----
        Req = 4'b0001; Delay[0 +: N] = 8'd7;              // cycle t
        repeat (4) tick();                                // t+4
        chk("r_q5", CntQ, 5);
        chk("r_grant_pre", Grant, 4'b0001);
        Reset = 1'b1;
        tick();                                           // t+5
        chk("r_grant", Grant, 0);
        chk("r_done", Done, 0);
        chk("r_busy", Busy, 0);
        chk("r_cntr", CntR, 0);
        chk("r_cntl", CntL, 0);
        chk("r_cnte", CntE, 0);
        Reset = 1'b0; Req = '0;
        seen = 1'b0;
        repeat (4) begin tick(); seen |= |Done; end
        chk("r_no_done", seen, 0);

        // ---- requester 1 withdraws mid COUNT ----
        Req = 4'b0010; Delay[1*N +: N] = 8'd4;            // cycle t
        repeat (3) tick();                                // t+3
        chk("w_q3", CntQ, 3);
        chk("w_grant", Grant, 4'b0010);
        Req = '0;
`ifdef COUNTDOWN_SCHED_ABORT_EN
        tick();                                           // t+4
        chk("w_abort_grant", Grant, 0);
        chk("w_abort_busy", Busy, 0);
        chk("w_abort_cnte", CntE, 0);
        seen = |Done;
        repeat (5) begin tick(); seen |= |Done; end
        chk("w_abort_no_done", seen, 0);
`else
        repeat (3) tick();                                // t+6
        chk("w_q0", CntQ, 0);
        chk("w_done_early", Done, 0);
        tick();                                           // t+7
        chk("w_done", Done, 4'b0010);
        chk("w_grant_held", Grant, 4'b0010);
        tick();
        chk("w_idle", Busy, 0);
`endif

        // ---- Delay changes after grant ----
        Req = 4'b1000; Delay[3*N +: N] = 8'd9;            // cycle t
        tick();                                           // t+1
        Delay[3*N +: N] = 8'd2;
        chk("d_cntr", CntR, 9);
        chk("d_grant", Grant, 4'b1000);
        tick();                                           // t+2
        chk("d_q9", CntQ, 9);
        repeat (9) tick();                                // t+11
        chk("d_done_early", Done, 0);
        tick();                                           // t+12
        chk("d_done", Done, 4'b1000);
        Req = '0;
        tick();
        chk("d_idle", Busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
